// File: rtl/icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl
//
// Line-fill controller for the instruction cache. It accepts a miss and sends
// one refill request to memory. It then joins two response beats (low half
// first) into one line and writes that line into a victim way. The victim way
// is chosen round-robin.
//
// Optional feature: define ICACHE_REFILL_ERR_EN to make a beat that carries
// mem_rsp_error_i abort the refill. The abort goes through a one-cycle ERR
// state that pulses error_o. When the macro is undefined, mem_rsp_error_i is
// ignored and error_o is tied low.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   miss_valid_i/idx_i     miss request from the lookup logic
//   miss_ready_o           controller is idle and can accept a miss
//   mem_req_valid_o/idx_o  refill request to memory, held until mem_req_ready_i
//   mem_rsp_*_i            response beats; memory never stalls a beat
//   way_req_o/we_o/addr_o/data_o  one-hot way write port, active in WRITE only
//   fill_way_o             victim way for the current or next fill
//   done_o / error_o       one-cycle completion / abort pulses
//   busy_o                 controller is not idle
// -----------------------------------------------------------------------------
module icache_refill_ctrl #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned WORD_SIZE  = 64,
    parameter int unsigned SET_WIDTH  = 128,
    parameter int unsigned NUM_WAYS   = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        miss_valid_i,
    input  logic [ADDR_WIDTH-1:0]       miss_idx_i,
    output logic                        miss_ready_o,
    output logic                        mem_req_valid_o,
    output logic [ADDR_WIDTH-1:0]       mem_req_idx_o,
    input  logic                        mem_req_ready_i,
    input  logic                        mem_rsp_valid_i,
    input  logic [WORD_SIZE-1:0]        mem_rsp_data_i,
    input  logic                        mem_rsp_error_i,
    output logic [NUM_WAYS-1:0]         way_req_o,
    output logic                        way_we_o,
    output logic [ADDR_WIDTH-1:0]       way_addr_o,
    output logic [SET_WIDTH-1:0]        way_data_o,
    output logic [$clog2(NUM_WAYS)-1:0] fill_way_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic                        busy_o
);

    localparam int unsigned VW = $clog2(NUM_WAYS);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_BEAT0 = 3'd2;
    localparam logic [2:0] ST_BEAT1 = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
`ifdef ICACHE_REFILL_ERR_EN
    localparam logic [2:0] ST_ERR   = 3'd5;
`endif

    localparam logic [VW-1:0]       VICTIM_ONE = 1;
    localparam logic [NUM_WAYS-1:0] WAY_ONE    = 1;

    logic [2:0]            state_q,    state_d;
    logic [ADDR_WIDTH-1:0] idx_q,      idx_d;
    logic [WORD_SIZE-1:0]  line_lo_q,  line_lo_d;
    logic [ADDR_WIDTH-1:0] way_addr_q, way_addr_d;
    logic [SET_WIDTH-1:0]  way_data_q, way_data_d;
    logic [VW-1:0]         victim_q,   victim_d;

`ifndef ICACHE_REFILL_ERR_EN
    logic unused_rsp_error;
    assign unused_rsp_error = mem_rsp_error_i;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        line_lo_d  = line_lo_q;
        way_addr_d = way_addr_q;
        way_data_d = way_data_q;
        victim_d   = victim_q;
        case (state_q)
            ST_IDLE: begin
                if (miss_valid_i) begin
                    idx_d   = miss_idx_i;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready_i) begin
                    state_d = ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                if (mem_rsp_valid_i) begin
                    line_lo_d = mem_rsp_data_i;
                    state_d   = ST_BEAT1;
`ifdef ICACHE_REFILL_ERR_EN
                    if (mem_rsp_error_i) begin
                        state_d = ST_ERR;
                    end
`endif
                end
            end
            ST_BEAT1: begin
                if (mem_rsp_valid_i) begin
                    // The write-port registers load only here. They keep their
                    // value until the next completed fill.
                    way_data_d = {mem_rsp_data_i, line_lo_q};
                    way_addr_d = idx_q;
                    state_d    = ST_WRITE;
`ifdef ICACHE_REFILL_ERR_EN
                    if (mem_rsp_error_i) begin
                        way_data_d = way_data_q;
                        way_addr_d = way_addr_q;
                        state_d    = ST_ERR;
                    end
`endif
                end
            end
            ST_WRITE: begin
                // NUM_WAYS is a power of two, so the natural wrap gives modulo.
                victim_d = victim_q + VICTIM_ONE;
                state_d  = ST_IDLE;
            end
`ifdef ICACHE_REFILL_ERR_EN
            ST_ERR: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            line_lo_q  <= '0;
            way_addr_q <= '0;
            way_data_q <= '0;
            victim_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            line_lo_q  <= line_lo_d;
            way_addr_q <= way_addr_d;
            way_data_q <= way_data_d;
            victim_q   <= victim_d;
        end
    end

    assign miss_ready_o    = (state_q == ST_IDLE);
    assign busy_o          = (state_q != ST_IDLE);
    assign mem_req_valid_o = (state_q == ST_REQ);
    assign mem_req_idx_o   = idx_q;
    assign way_we_o        = (state_q == ST_WRITE);
    assign way_req_o       = (state_q == ST_WRITE) ? (WAY_ONE << victim_q) : '0;
    assign way_addr_o      = way_addr_q;
    assign way_data_o      = way_data_q;
    assign fill_way_o      = victim_q;
    assign done_o          = (state_q == ST_WRITE);
`ifdef ICACHE_REFILL_ERR_EN
    assign error_o         = (state_q == ST_ERR);
`else
    assign error_o         = 1'b0;
`endif

endmodule
